// File: rtl/lsu_mem.sv
// Load/store unit memory stage: formats requests onto a single-outstanding data bus
// and aligns/extends load responses back to the pipeline.
module lsu_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_mem_rd,
    input  logic        lsu_mem_wr,
    input  logic [2:0]  lsu_mem_op,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic        lsu_flush,
    output logic        lsu_stall,
    output logic [31:0] lsu_load_data,
    output logic        lsu_load_valid,
    output logic        lsu_load_misaligned,
    output logic        lsu_store_misaligned,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;

    state_t      state_q, state_d;
    logic        kill_q, kill_d;
    logic        we_q, we_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        ld_mis_q, ld_mis_d;
    logic        st_mis_q, st_mis_d;

    logic        in_idle, any_req, aligned, req_valid;
    logic        src_we;
    logic [2:0]  src_op;
    logic [31:0] src_addr, src_wdata;
    logic        req_c, stall_c;

    function automatic logic [31:0] fmt_load(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (op)
            3'b000:  fmt_load = {{24{sh[7]}}, sh[7:0]};
            3'b001:  fmt_load = {{16{sh[15]}}, sh[15:0]};
            3'b100:  fmt_load = {24'd0, sh[7:0]};
            3'b101:  fmt_load = {16'd0, sh[15:0]};
            default: fmt_load = sh;
        endcase
    endfunction

    always_comb begin
        in_idle  = (state_q == IDLE);
        any_req  = lsu_mem_rd | lsu_mem_wr;
        case (lsu_mem_op[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~lsu_addr[0];
            default: aligned = (lsu_addr[1:0] == 2'b00);
        endcase
        req_valid = in_idle & any_req & ~lsu_flush & aligned;

        // Same cycle as the request the bus sees the raw inputs; afterwards the held copy
        src_we    = in_idle ? lsu_mem_wr : we_q;
        src_op    = in_idle ? lsu_mem_op : op_q;
        src_addr  = in_idle ? lsu_addr   : addr_q;
        src_wdata = in_idle ? lsu_wdata  : wdata_q;

        dbus_we   = src_we;
        dbus_addr = {src_addr[31:2], 2'b00};
        case (src_op[1:0])
            2'b00: begin
                dbus_be    = 4'b0001 << src_addr[1:0];
                dbus_wdata = {4{src_wdata[7:0]}};
            end
            2'b01: begin
                dbus_be    = src_addr[1] ? 4'b1100 : 4'b0011;
                dbus_wdata = {2{src_wdata[15:0]}};
            end
            default: begin
                dbus_be    = 4'b1111;
                dbus_wdata = src_wdata;
            end
        endcase

        state_d      = state_q;
        kill_d       = kill_q;
        we_d         = we_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        ld_mis_d     = 1'b0;
        st_mis_d     = 1'b0;
        req_c        = 1'b0;
        stall_c      = 1'b0;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (in_idle & any_req & ~lsu_flush & ~aligned) begin
                    st_mis_d = lsu_mem_wr;
                    ld_mis_d = ~lsu_mem_wr;
                end
                if (req_valid) begin
                    req_c   = 1'b1;
                    we_d    = lsu_mem_wr;
                    op_d    = lsu_mem_op;
                    addr_d  = lsu_addr;
                    wdata_d = lsu_wdata;
                    stall_c = ~(lsu_mem_wr & dbus_gnt);
                    if (!dbus_gnt)
                        state_d = WAIT_GNT;
                    else if (!lsu_mem_wr)
                        state_d = WAIT_RSP;
                end
            end
            WAIT_GNT: begin
                if (lsu_flush) begin
                    state_d = IDLE;
                end else begin
                    req_c   = 1'b1;
                    stall_c = ~(we_q & dbus_gnt);
                    if (dbus_gnt)
                        state_d = we_q ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                stall_c = ~dbus_rvalid;
                if (lsu_flush)
                    kill_d = 1'b1;
                if (dbus_rvalid) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                    if (!(kill_q | lsu_flush)) begin
                        load_valid_d = 1'b1;
                        load_data_d  = fmt_load(op_q, addr_q[1:0], dbus_rdata);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbus_req             = rst & req_c;
    assign lsu_stall            = rst & stall_c;
    assign lsu_load_data        = load_data_q;
    assign lsu_load_valid       = load_valid_q;
    assign lsu_load_misaligned  = ld_mis_q;
    assign lsu_store_misaligned = st_mis_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            kill_q       <= 1'b0;
            we_q         <= 1'b0;
            op_q         <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            ld_mis_q     <= 1'b0;
            st_mis_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            kill_q       <= kill_d;
            we_q         <= we_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            ld_mis_q     <= ld_mis_d;
            st_mis_q     <= st_mis_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: bus formatting, FSM timing, flush, misalignment and reset.
module tb_lsu_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_mem_rd, lsu_mem_wr, lsu_flush;
    logic [2:0]  lsu_mem_op;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        lsu_stall, lsu_load_valid, lsu_load_misaligned, lsu_store_misaligned;
    logic [31:0] lsu_load_data;
    logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;

    int n_chk  = 0;
    int n_pass = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    lsu_mem dut (
        .clk(clk), .rst(rst),
        .lsu_mem_rd(lsu_mem_rd), .lsu_mem_wr(lsu_mem_wr), .lsu_mem_op(lsu_mem_op),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_flush(lsu_flush),
        .lsu_stall(lsu_stall), .lsu_load_data(lsu_load_data), .lsu_load_valid(lsu_load_valid),
        .lsu_load_misaligned(lsu_load_misaligned), .lsu_store_misaligned(lsu_store_misaligned),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_be(dbus_be), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Step past the rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lsu_mem_rd = 0; lsu_mem_wr = 0; lsu_flush = 0;
        dbus_gnt = 0; dbus_rvalid = 0;
    endtask

    // Load with same-cycle grant and response on the following cycle.
    task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_data);
        lsu_mem_rd = 1; lsu_mem_op = op; lsu_addr = addr; dbus_gnt = 1;
        #2;
        chk({tag, "_req"}, {31'd0, dbus_req}, 32'd1);
        chk({tag, "_be"}, {28'd0, dbus_be}, {28'd0, exp_be});
        tick();
        dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = rdata;
        tick();
        idle_inputs();
        chk({tag, "_vld"}, {31'd0, lsu_load_valid}, 32'd1);
        chk({tag, "_data"}, lsu_load_data, exp_data);
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        lsu_mem_op = 3'b010; lsu_addr = 32'h0; lsu_wdata = 32'h0; dbus_rdata = 32'h0;
        #12;
        lsu_mem_rd = 1;
        #1;
        chk("rst_req", {31'd0, dbus_req}, 32'd0);
        chk("rst_stall", {31'd0, lsu_stall}, 32'd0);
        chk("rst_data", lsu_load_data, 32'd0);
        chk("rst_vld", {31'd0, lsu_load_valid}, 32'd0);
        chk("rst_mis", {30'd0, lsu_load_misaligned, lsu_store_misaligned}, 32'd0);
        lsu_mem_rd = 0;
        tick();
        rst = 1;
        tick();

        // LW 0x100: grant with request, response after two waiting cycles
        lsu_mem_rd = 1; lsu_mem_op = 3'b010; lsu_addr = 32'h100; dbus_gnt = 1;
        #2;
        chk("lw_req", {31'd0, dbus_req}, 32'd1);
        chk("lw_we", {31'd0, dbus_we}, 32'd0);
        chk("lw_addr", dbus_addr, 32'h100);
        chk("lw_be", {28'd0, dbus_be}, 32'hF);
        stall_cnt = int'(lsu_stall);
        tick();
        dbus_gnt = 0;
        #2;
        chk("lw_req_rsp", {31'd0, dbus_req}, 32'd0);
        stall_cnt += int'(lsu_stall);
        tick();
        #2;
        stall_cnt += int'(lsu_stall);
        tick();
        dbus_rvalid = 1; dbus_rdata = 32'hDEADBEEF;
        #2;
        chk("lw_stall_rv", {31'd0, lsu_stall}, 32'd0);
        stall_cnt += int'(lsu_stall);
        chk("lw_stall_cnt", stall_cnt, 32'd3);
        tick();
        idle_inputs();
        chk("lw_vld", {31'd0, lsu_load_valid}, 32'd1);
        chk("lw_data", lsu_load_data, 32'hDEADBEEF);
        tick();
        chk("lw_vld_pulse", {31'd0, lsu_load_valid}, 32'd0);
        chk("lw_data_hold", lsu_load_data, 32'hDEADBEEF);

        do_load("lb", 3'b000, 32'h103, 32'h80FFFF00, 4'b1000, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h103, 32'h80FFFF00, 4'b1000, 32'h00000080);
        do_load("lh", 3'b001, 32'h102, 32'h80FFFF00, 4'b1100, 32'hFFFF80FF);
        do_load("lhu", 3'b101, 32'h102, 32'h80FFFF00, 4'b1100, 32'h000080FF);
        do_load("lb1", 3'b000, 32'h101, 32'h00007F00, 4'b0010, 32'h0000007F);

        // SH 0x202 with grant withheld for three cycles
        lsu_mem_wr = 1; lsu_mem_op = 3'b001; lsu_addr = 32'h202; lsu_wdata = 32'h1234;
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            dbus_gnt = (i == 3);
            #2;
            chk($sformatf("sh_req%0d", i), {31'd0, dbus_req}, 32'd1);
            chk($sformatf("sh_be%0d", i), {28'd0, dbus_be}, 32'hC);
            chk($sformatf("sh_wd%0d", i), dbus_wdata, 32'h12341234);
            chk($sformatf("sh_ad%0d", i), dbus_addr, 32'h200);
            chk($sformatf("sh_we%0d", i), {31'd0, dbus_we}, 32'd1);
            stall_cnt += int'(lsu_stall);
            tick();
        end
        idle_inputs();
        chk("sh_stall_cnt", stall_cnt, 32'd3);
        #2;
        chk("sh_done_req", {31'd0, dbus_req}, 32'd0);
        tick();

        // SB with immediate grant: no stall
        lsu_mem_wr = 1; lsu_mem_op = 3'b000; lsu_addr = 32'h201; lsu_wdata = 32'h55AB; dbus_gnt = 1;
        #2;
        chk("sb_be", {28'd0, dbus_be}, 32'h2);
        chk("sb_wd", dbus_wdata, 32'hABABABAB);
        chk("sb_stall", {31'd0, lsu_stall}, 32'd0);
        tick();
        idle_inputs();

        // Misaligned accesses
        lsu_mem_rd = 1; lsu_mem_op = 3'b010; lsu_addr = 32'h101;
        #2;
        chk("lwmis_req", {31'd0, dbus_req}, 32'd0);
        chk("lwmis_stall", {31'd0, lsu_stall}, 32'd0);
        tick();
        idle_inputs();
        chk("lwmis_pulse", {30'd0, lsu_load_misaligned, lsu_store_misaligned}, 32'h2);
        tick();
        chk("lwmis_clear", {31'd0, lsu_load_misaligned}, 32'd0);
        lsu_mem_wr = 1; lsu_mem_op = 3'b001; lsu_addr = 32'h3;
        #2;
        chk("shmis_req", {31'd0, dbus_req}, 32'd0);
        tick();
        idle_inputs();
        chk("shmis_pulse", {30'd0, lsu_load_misaligned, lsu_store_misaligned}, 32'h1);
        lsu_mem_rd = 1; lsu_mem_op = 3'b010; lsu_addr = 32'h104; lsu_flush = 1;
        #2;
        chk("flushed_req", {31'd0, dbus_req}, 32'd0);
        tick();
        idle_inputs();

        // Flush while waiting for grant
        lsu_mem_rd = 1; lsu_mem_op = 3'b010; lsu_addr = 32'h100;
        tick();
        #2;
        chk("fg_req", {31'd0, dbus_req}, 32'd1);
        lsu_flush = 1;
        #1;
        chk("fg_req_drop", {31'd0, dbus_req}, 32'd0);
        chk("fg_stall", {31'd0, lsu_stall}, 32'd0);
        tick();
        idle_inputs();
        dbus_rvalid = 1; dbus_rdata = 32'h77777777;
        #2;
        chk("fg_idle_req", {31'd0, dbus_req}, 32'd0);
        tick();
        dbus_rvalid = 0;
        chk("fg_vld", {31'd0, lsu_load_valid}, 32'd0);

        // Flush while waiting for response
        lsu_mem_rd = 1; lsu_mem_op = 3'b010; lsu_addr = 32'h100; dbus_gnt = 1;
        tick();
        dbus_gnt = 0; lsu_flush = 1;
        tick();
        lsu_flush = 0; dbus_rvalid = 1; dbus_rdata = 32'h11111111;
        #2;
        chk("fr_stall", {31'd0, lsu_stall}, 32'd0);
        tick();
        idle_inputs();
        chk("fr_vld", {31'd0, lsu_load_valid}, 32'd0);
        chk("fr_data", lsu_load_data, 32'h0000007F);
        do_load("after_kill", 3'b010, 32'h104, 32'h00000055, 4'hF, 32'h00000055);

        // Reset asserted while waiting for response
        lsu_mem_rd = 1; lsu_mem_op = 3'b010; lsu_addr = 32'h108; dbus_gnt = 1;
        tick();
        dbus_gnt = 0;
        rst = 0;
        #1;
        chk("rr_stall", {31'd0, lsu_stall}, 32'd0);
        chk("rr_req", {31'd0, dbus_req}, 32'd0);
        chk("rr_data", lsu_load_data, 32'd0);
        lsu_mem_rd = 0;
        tick();
        rst = 1;
        tick();
        dbus_rvalid = 1; dbus_rdata = 32'hCAFEF00D;
        tick();
        dbus_rvalid = 0;
        chk("rr_late_vld", {31'd0, lsu_load_valid}, 32'd0);
        chk("rr_late_data", lsu_load_data, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
